// File: rtl/obj_line_buffer.sv
// Double-buffered object line store: opaque pixel pairs go into the back buffer
// while the front buffer is scanned out (and optionally cleared) one pixel per enable.
module obj_line_buffer #(
  parameter bit CLR_ON_READ = 1'b1,
  parameter int XW          = 8
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_INITRST_n,
  input  logic          i_EMU_CLK6MPCEN_n,
  input  logic [7:0]    i_DA,
  input  logic [7:0]    i_DB,
  input  logic [XW-1:0] i_WRX,
  input  logic          i_WR_n,
  input  logic [XW-1:0] i_HCOUNT,
  input  logic          i_HBLANK_n,
  input  logic          i_LINESWAP,
  output logic [7:0]    o_PIXEL,
  output logic          o_OPAQUE,
  output logic          o_READY
);

  localparam int AW    = XW - 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q;
  logic [AW-1:0] clr_addr_q;
  logic          sel_q;
  logic [7:0]    rd_q;
  logic [7:0]    pix_q;
  logic          ready_q;

  logic          en;
  logic          run;
  logic          clr_all;
  logic          rd_en;
  logic          wr_da;
  logic          wr_db;
  logic [AW-1:0] wr_even_addr;
  logic [AW-1:0] wr_odd_addr;
  logic [AW-1:0] rd_addr;
  logic [3:0][7:0] bank_rdata;

  assign en      = ~i_EMU_CLK6MPCEN_n;
  assign run     = (state_q == ST_RUN);
  assign clr_all = en & ~run;
  assign rd_en   = en & run & i_HBLANK_n;
  // A zero pixel nibble is transparent and must not disturb what is already stored.
  assign wr_da   = en & run & ~i_WR_n & (i_DA[3:0] != 4'h0);
  assign wr_db   = en & run & ~i_WR_n & (i_DB[3:0] != 4'h0);

  // Odd x puts DA at the next even pixel; x=255 wraps that to address 0.
  assign wr_even_addr = i_WRX[XW-1:1] + {{(AW-1){1'b0}}, i_WRX[0]};
  assign wr_odd_addr  = i_WRX[XW-1:1];
  assign rd_addr      = i_HCOUNT[XW-1:1];

  // Bank index b = {buffer, odd}: one write port per bank, shared by clear, write and clear-on-read.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    localparam logic BUF_ID = 1'(b / 2);
    localparam logic ODD    = 1'(b % 2);

    logic [7:0]    mem_q [DEPTH];
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;

    always_comb begin
      we = 1'b0;
      wa = clr_addr_q;
      wd = 8'h00;
      if (clr_all) begin
        we = 1'b1;
      end else if (BUF_ID != sel_q) begin
        we = ODD ? wr_db : wr_da;
        wa = ODD ? wr_odd_addr : wr_even_addr;
        wd = ODD ? i_DB : i_DA;
      end else if (CLR_ON_READ && rd_en && (i_HCOUNT[0] == ODD)) begin
        we = 1'b1;
        wa = rd_addr;
      end
    end

    always_ff @(posedge i_EMU_MCLK) begin
      if (we) mem_q[wa] <= wd;
    end

    assign bank_rdata[b] = mem_q[rd_addr];
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_INITRST_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      sel_q      <= 1'b0;
      rd_q       <= 8'h00;
      pix_q      <= 8'h00;
      ready_q    <= 1'b0;
    end else if (en) begin
      pix_q <= rd_q;
      case (state_q)
        ST_CLEAR: begin
          rd_q       <= 8'h00;
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == {AW{1'b1}}) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          rd_q <= i_HBLANK_n ? bank_rdata[{sel_q, i_HCOUNT[0]}] : 8'h00;
          if (i_LINESWAP) sel_q <= ~sel_q;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign o_PIXEL  = pix_q;
  assign o_OPAQUE = (pix_q[3:0] != 4'h0);
  assign o_READY  = ready_q;

endmodule

// File: tb/tb_obj_line_buffer.sv
// Bench for obj_line_buffer: directed test-plan steps plus random traffic, checked
// against a pixel-indexed line model of both buffers for clear-on-read and persistent variants.
module tb_obj_line_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen_n = 1'b1;
  logic [7:0] da = 8'h00, db = 8'h00, wrx = 8'h00, hcount = 8'h00;
  logic       wr_n = 1'b1, hblank_n = 1'b0, lineswap = 1'b0;
  logic [7:0] pix, pix_nc;
  logic       opq, opq_nc, rdy, rdy_nc;

  int checks = 0;
  int errors = 0;

  // Reference: buffers indexed by screen x, per instance (0 = clear-on-read, 1 = persistent).
  logic [7:0] m_buf [2][2][256];
  logic       m_sel [2];
  logic       m_ready;
  int         m_clr_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] exp_nc_q[$];
  logic [7:0] exp_pix [2];

  always #5 clk = ~clk;

  obj_line_buffer #(.CLR_ON_READ(1'b1), .XW(8)) dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_DA(da), .i_DB(db), .i_WRX(wrx), .i_WR_n(wr_n), .i_HCOUNT(hcount),
    .i_HBLANK_n(hblank_n), .i_LINESWAP(lineswap),
    .o_PIXEL(pix), .o_OPAQUE(opq), .o_READY(rdy)
  );

  obj_line_buffer #(.CLR_ON_READ(1'b0), .XW(8)) dut_nc (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_DA(da), .i_DB(db), .i_WRX(wrx), .i_WR_n(wr_n), .i_HCOUNT(hcount),
    .i_HBLANK_n(hblank_n), .i_LINESWAP(lineswap),
    .o_PIXEL(pix_nc), .o_OPAQUE(opq_nc), .o_READY(rdy_nc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel[0] = 1'b0;
    m_sel[1] = 1'b0;
    m_ready = 1'b0;
    m_clr_cnt = 0;
    exp_q.delete();
    exp_nc_q.delete();
    exp_q.push_back(8'h00);
    exp_nc_q.push_back(8'h00);
    exp_pix[0] = 8'h00;
    exp_pix[1] = 8'h00;
  endtask

  task automatic model_enable();
    logic [7:0] rd_new;
    logic [7:0] da_x, db_x;
    logic       front;
    da_x = wrx[0] ? wrx + 8'd1 : wrx;
    db_x = wrx[0] ? wrx : wrx + 8'd1;
    for (int i = 0; i < 2; i++) begin
      rd_new = 8'h00;
      if (m_ready) begin
        front = m_sel[i];
        if (hblank_n) begin
          rd_new = m_buf[i][front][hcount];
          if (i == 0) m_buf[i][front][hcount] = 8'h00;
        end
        if (!wr_n) begin
          if (da[3:0] != 4'h0) m_buf[i][~front][da_x] = da;
          if (db[3:0] != 4'h0) m_buf[i][~front][db_x] = db;
        end
        if (lineswap) m_sel[i] = ~m_sel[i];
      end
      if (i == 0) begin
        exp_pix[0] = exp_q.pop_front();
        exp_q.push_back(rd_new);
      end else begin
        exp_pix[1] = exp_nc_q.pop_front();
        exp_nc_q.push_back(rd_new);
      end
    end
    if (!m_ready) begin
      m_clr_cnt++;
      if (m_clr_cnt == 128) begin
        m_ready = 1'b1;
        for (int i = 0; i < 2; i++)
          for (int k = 0; k < 2; k++)
            for (int x = 0; x < 256; x++) m_buf[i][k][x] = 8'h00;
      end
    end
  endtask

  task automatic compare_all();
    check("pixel", {24'h0, pix}, {24'h0, exp_pix[0]});
    check("pixel_nc", {24'h0, pix_nc}, {24'h0, exp_pix[1]});
    check("opaque", {31'h0, opq}, {31'h0, exp_pix[0][3:0] != 4'h0});
    check("ready", {31'h0, rdy}, {31'h0, m_ready});
    check("ready_nc", {31'h0, rdy_nc}, {31'h0, m_ready});
  endtask

  // One clock edge, enabled or not; model follows the same edge.
  task automatic step(input bit en);
    cen_n = ~en;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (en) model_enable();
    #1;
    compare_all();
    cen_n = 1'b1;
  endtask

  task automatic en_step();
    int idle;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) step(1'b0);
    step(1'b1);
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    while (!rdy && n < 200) begin
      wr_n = 1'($urandom_range(0, 1));
      lineswap = 1'($urandom_range(0, 1));
      hblank_n = 1'b1;
      da = 8'($urandom);
      db = 8'($urandom);
      wrx = 8'($urandom);
      hcount = 8'($urandom);
      en_step();
      n++;
    end
    check(tag, n, 128);
    wr_n = 1'b1;
    lineswap = 1'b0;
    hblank_n = 1'b0;
  endtask

  task automatic write_pair(input logic [7:0] x, input logic [7:0] a, input logic [7:0] b,
                            input bit swap);
    wrx = x; da = a; db = b; wr_n = 1'b0; lineswap = swap; hblank_n = 1'b0;
    en_step();
    wr_n = 1'b1; lineswap = 1'b0;
  endtask

  task automatic do_swap();
    lineswap = 1'b1;
    en_step();
    lineswap = 1'b0;
  endtask

  task automatic read_x(input logic [7:0] x, output logic [7:0] v, output logic [7:0] v_nc);
    hcount = x; hblank_n = 1'b1;
    en_step();
    hblank_n = 1'b0;
    en_step();
    v = pix;
    v_nc = pix_nc;
  endtask

  task automatic scan_line(output logic [7:0] acc);
    acc = 8'h00;
    hblank_n = 1'b0;
    en_step();
    en_step();
    for (int x = 0; x < 256; x++) begin
      hcount = 8'(x); hblank_n = 1'b1;
      en_step();
      acc |= pix;
    end
    hblank_n = 1'b0;
    en_step(); acc |= pix;
    en_step(); acc |= pix;
  endtask

  initial begin
    logic [7:0] v, v_nc, acc;

    // Reset and post-reset clear length.
    rst_n = 1'b0;
    step(1'b1); step(1'b0); step(1'b1);
    check("rst_pixel", {24'h0, pix}, 32'h0);
    check("rst_ready", {31'h0, rdy}, 32'h0);
    rst_n = 1'b1;
    count_clear("clear_len");

    // Both buffers read back empty.
    scan_line(acc);
    check("empty_front", {24'h0, acc}, 32'h0);
    do_swap();
    scan_line(acc);
    check("empty_back", {24'h0, acc}, 32'h0);

    // Even-aligned pair.
    write_pair(8'h10, 8'h35, 8'h3A, 1'b0);
    do_swap();
    read_x(8'h10, v, v_nc); check("even_da", {24'h0, v}, 32'h35);
    read_x(8'h11, v, v_nc); check("even_db", {24'h0, v}, 32'h3A);
    check("even_db_nc", {24'h0, v_nc}, 32'h3A);
    read_x(8'h12, v, v_nc); check("even_other", {24'h0, v}, 32'h0);

    // Odd-aligned pair and the x=255 wrap.
    write_pair(8'h11, 8'h27, 8'h24, 1'b0);
    write_pair(8'hFF, 8'h51, 8'h00, 1'b0);
    do_swap();
    read_x(8'h12, v, v_nc); check("odd_da", {24'h0, v}, 32'h27);
    read_x(8'h11, v, v_nc); check("odd_db", {24'h0, v}, 32'h24);
    read_x(8'h00, v, v_nc); check("wrap_da", {24'h0, v}, 32'h51);

    // Transparency, then opaque overwrite.
    write_pair(8'h20, 8'h4C, 8'h00, 1'b0);
    write_pair(8'h20, 8'h90, 8'h00, 1'b0);
    do_swap();
    read_x(8'h20, v, v_nc); check("transparent", {24'h0, v}, 32'h4C);
    write_pair(8'h20, 8'h4C, 8'h00, 1'b0);
    write_pair(8'h20, 8'h93, 8'h00, 1'b0);
    do_swap();
    read_x(8'h20, v, v_nc); check("overwrite", {24'h0, v}, 32'h93);

    // Clear-on-read versus persistent contents.
    write_pair(8'h30, 8'h35, 8'h00, 1'b0);
    do_swap();
    scan_line(acc);
    do_swap();
    do_swap();
    scan_line(acc);
    check("clr_on_read", {24'h0, acc}, 32'h0);
    read_x(8'h30, v, v_nc);
    check("persist_nc", {24'h0, v_nc}, 32'h35);

    // Swap in the same cycle as a write: data lands in the pre-swap back buffer.
    write_pair(8'h40, 8'h66, 8'h00, 1'b1);
    read_x(8'h40, v, v_nc); check("swap_write", {24'h0, v}, 32'h66);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wr_n = 1'($urandom_range(0, 1));
      wrx = 8'($urandom);
      da = {4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15))};
      db = {4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15))};
      hcount = 8'($urandom);
      hblank_n = ($urandom_range(0, 3) != 0);
      lineswap = ($urandom_range(0, 15) == 0);
      en_step();
    end
    wr_n = 1'b1; lineswap = 1'b0;

    // Reset mid-scan with the enable inactive.
    write_pair(8'h60, 8'h7E, 8'h00, 1'b0);
    do_swap();
    hcount = 8'h60; hblank_n = 1'b1;
    en_step();
    rst_n = 1'b0;
    step(1'b0);
    check("midscan_pixel", {24'h0, pix}, 32'h0);
    check("midscan_ready", {31'h0, rdy}, 32'h0);
    rst_n = 1'b1;
    hblank_n = 1'b0;
    for (int i = 0; i < 50; i++) en_step();
    rst_n = 1'b0;
    step(1'b1);
    rst_n = 1'b1;
    count_clear("reclear_len");
    write_pair(8'h50, 8'h77, 8'h00, 1'b0);
    do_swap();
    read_x(8'h50, v, v_nc); check("after_reclear", {24'h0, v}, 32'h77);
    read_x(8'h60, v, v_nc); check("reclear_zero", {24'h0, v_nc}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obj_line_buffer.md
Name: obj_line_buffer

Overview:
- Double-buffered object line store directly downstream of the object line latch.
- Accepts the latch's DA/DB pixel-pair outputs, each {palette[3:0], pixel[3:0]}, and writes opaque pixels into the back buffer.
- Simultaneously scans the front buffer out one pixel per 6 MHz enable, and clears each location as it is read.
- Buffers swap once per line; output feeds the priority/colour mixer.

Parameters:
- CLR_ON_READ, 1, when 1 the front-buffer location is zeroed on the same cycle it is read; when 0 contents persist.
- XW, 8, pixel x width; each bank is 2^(XW-1) words deep; fixed 8 for this board.

Ports:
- i_EMU_MCLK  in  1  master clock; all logic is on posedge.
- i_EMU_INITRST_n  in  1  synchronous active-low reset, sampled on posedge i_EMU_MCLK regardless of clock enable.
- i_EMU_CLK6MPCEN_n  in  1  active-low 6 MHz clock enable; every state change except reset is qualified by it.
- i_DA  in  8  even-bank write data from the line latch.
- i_DB  in  8  odd-bank write data from the line latch.
- i_WRX  in  XW  x position of the pixel pair being written.
- i_WR_n  in  1  active-low write strobe.
- i_HCOUNT  in  XW  read x position of the front buffer.
- i_HBLANK_n  in  1  low during horizontal blank.
- i_LINESWAP  in  1  one-enable-cycle pulse that swaps front and back buffers.
- o_PIXEL  out  8  {palette, pixel} of the scanned-out object pixel.
- o_OPAQUE  out  1  high when o_PIXEL[3:0] != 0.
- o_READY  out  1  high once the post-reset clear has finished.

Behaviour:
- Storage: two line buffers (L0, L1). Each has an even bank and an odd bank, 128 x 8 bits each.
- Register sel selects the front buffer; the back buffer is ~sel.
- Write address mapping for i_WRX = x:
  - Even-bank address = (x[7:1] + x[0]) mod 128. When x is odd, DA carries pixel x+1.
  - Odd-bank address = x[7:1].
  - x = 255 wraps the even write to address 0.
- Write rule, per enable with i_WR_n=0 and o_READY=1:
  - Back-buffer even bank is written with i_DA only if i_DA[3:0] != 0.
  - Back-buffer odd bank is written with i_DB only if i_DB[3:0] != 0.
  - Zero nibble means transparent: the stored value is left untouched.
  - Later writes overwrite earlier opaque data.
- Read rule, per enable with i_HBLANK_n=1:
  - The bank is chosen by i_HCOUNT[0]; the address is i_HCOUNT[7:1].
  - The front-buffer word is captured into rd_q.
  - If CLR_ON_READ=1, that location is written 0 in the same cycle. Read returns the old data.
- Output: o_PIXEL <= rd_q on the next enable.
  - Latency is 2 enables from i_HCOUNT to o_PIXEL.
  - While i_HBLANK_n=0: rd_q loads 0, no clear occurs, and o_PIXEL drains to 0 after 2 enables.
- o_OPAQUE is a combinational decode of o_PIXEL[3:0].
- Swap: on an enable with i_LINESWAP=1, sel toggles. A write or read in that same cycle uses the pre-toggle sel.
- Write and read always target different buffers, so there is never a port conflict.
- FSM: CLEAR -> RUN.
  - Reset: state=CLEAR, clr_addr=0, sel=0, rd_q=0, o_PIXEL=0, o_READY=0. RAM contents are not reset by the reset itself.
  - CLEAR: each enable writes 0 to clr_addr in all four banks; clr_addr increments.
  - After clr_addr=127 is written, the next state is RUN and o_READY=1, giving exactly 128 enables.
  - During CLEAR, i_WR_n, i_LINESWAP and reads are ignored and o_PIXEL stays 0.
  - RUN is terminal until reset.
- Reset asserted mid-line or mid-CLEAR restarts CLEAR from address 0 on the next clock.
- Enable high (inactive): all registers hold, including in CLEAR.

Test Plan:
- Reset, then count enables -> o_READY rises after exactly 128 enables. A read of every x in both buffers then returns 0x00.
- Write i_WRX=0x10, DA=0x35, DB=0x3A; swap; scan -> o_PIXEL=0x35 at x=0x10 and 0x3A at x=0x11, each 2 enables after the matching i_HCOUNT. Other x read 0x00.
- Write i_WRX=0x11 (odd), DA=0x27, DB=0x24 -> after swap, x=0x12 reads 0x27 and x=0x11 reads 0x24. i_WRX=0xFF with DA=0x51 -> x=0x00 reads 0x51.
- Transparency: preload x=0x20 with 0x4C, then write DA=0x90 at the same pair -> x=0x20 still reads 0x4C. A later DA=0x93 overwrites it -> reads 0x93.
- Clear-on-read: scan a line containing 0x35, swap twice, scan again -> 0x00 everywhere. With CLR_ON_READ=0 -> 0x35 persists.
- Assert i_EMU_INITRST_n low mid-scan, and issue i_LINESWAP in the same cycle as a write -> sel=0, o_PIXEL=0, CLEAR restarts. In the non-reset case, the write lands in the pre-swap back buffer.
